seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scanner for the debug 7-segment display. A 32-bit debug
//   word is accepted over a valid/ready handshake into a pending buffer and
//   promoted to the display register only at frame boundaries, so a frame
//   never mixes two words. Each digit slot is an all-off BLANK gap followed by
//   a DRIVE window where exactly one active-low enable is low.
//
//   Optional feature macro: SEG_SCAN_LEADING_ZERO_BLANK_EN
//     When defined, digits above the most significant nonzero nibble of the
//     display word stay dark during their DRIVE window (digit 0 always shown).
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   load_valid    load_data is valid this cycle
//   load_data     32-bit debug word to display
//   load_ready    pending buffer empty (registered)
//   hold          while high, the pending word is not promoted
//   digit_number  {28'b0, nibble of the current slot} for the hex decoder
//   digit_en_n    active-low digit enables, at most one low
//   digit_idx     index of the current digit slot
//   frame_done    high during the final DRIVE cycle of the last digit
//
// Handshake: a word transfers on a clk edge where load_valid && load_ready.
// load_ready is low from the cycle after a transfer until the cycle after the
// frame boundary that promotes the word; the producer holds load_valid (and
// load_data) until it sees the transfer happen.

module seg_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_GAP   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load_valid,
   input  logic [31:0]           load_data,
   output logic                  load_ready,
   input  logic                  hold,
   output logic [31:0]           digit_number,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic [2:0]            digit_idx,
   output logic                  frame_done
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_GAP)
                            ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                            : ((BLANK_GAP > 2) ? BLANK_GAP : 2);
   localparam int CW = $clog2(CNT_MAX);

   localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // With no blanking gap every slot starts directly in DRIVE.
   localparam state_t SLOT_START = (BLANK_GAP > 0) ? S_BLANK : S_DRIVE;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [31:0]     display;
   logic [31:0]     pending;
   logic            pend_full;
   logic [3:0]      nib;

   // Next-state values, all registered below.
   state_t          state_nxt;
   logic [CW-1:0]   cnt_nxt;
   logic [2:0]      idx_nxt;
   logic [31:0]     display_nxt;
   logic            pend_full_nxt;
   logic [NUM_DIGITS-1:0] en_nxt;
   logic            fd_nxt;
   logic            accept;
   logic            promote;
   logic            slot_end;
   logic            blank_end;
   logic [2:0]      shown_top;   // highest digit index allowed to light

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   logic [2:0] msd;
   logic [2:0] msd_nxt;

   function automatic logic [2:0] calc_msd(input logic [31:0] w);
      logic [2:0] m;
      m = 3'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (w[4*k +: 4] != 4'h0) m = 3'(k);
      end
      return m;
   endfunction
`endif

   function automatic logic [NUM_DIGITS-1:0] drive_pattern(input logic [2:0] i,
                                                           input logic [2:0] top);
      logic [NUM_DIGITS-1:0] p;
      p = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((i == 3'(k)) && (i <= top)) p[k] = 1'b0;
      end
      return p;
   endfunction

   always_comb begin
      accept        = load_valid && load_ready;
      // frame_done is high exactly in the last cycle of the frame, so the
      // edge ending it is the frame boundary.
      promote       = frame_done && pend_full && !hold;
      display_nxt   = promote ? pending : display;
      pend_full_nxt = pend_full;
      if (accept)       pend_full_nxt = 1'b1;
      else if (promote) pend_full_nxt = 1'b0;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      msd_nxt   = promote ? calc_msd(pending) : msd;
      shown_top = msd_nxt;
`else
      shown_top = LAST_IDX;
`endif

      slot_end  = (state == S_DRIVE) && (cnt == DRIVE_LAST);
      blank_end = (state == S_BLANK) && (cnt == BLANK_LAST);

      idx_nxt   = digit_idx;
      state_nxt = state;
      cnt_nxt   = cnt + CNT_ONE;
      if (slot_end) begin
         idx_nxt   = (digit_idx == LAST_IDX) ? 3'd0 : digit_idx + 3'd1;
         state_nxt = SLOT_START;
         cnt_nxt   = '0;
      end else if (blank_end) begin
         state_nxt = S_DRIVE;
         cnt_nxt   = '0;
      end

      en_nxt = (state_nxt == S_DRIVE) ? drive_pattern(idx_nxt, shown_top) : '1;
      fd_nxt = (state_nxt == S_DRIVE) && (idx_nxt == LAST_IDX) && (cnt_nxt == DRIVE_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= SLOT_START;
         cnt        <= '0;
         digit_idx  <= 3'd0;
         display    <= '0;
         pending    <= '0;
         pend_full  <= 1'b0;
         load_ready <= 1'b1;
         nib        <= 4'h0;
         digit_en_n <= '1;
         frame_done <= 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
         msd        <= 3'd0;
`endif
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         digit_idx  <= idx_nxt;
         display    <= display_nxt;
         pend_full  <= pend_full_nxt;
         load_ready <= !pend_full_nxt;
         digit_en_n <= en_nxt;
         frame_done <= fd_nxt;
         if (accept) pending <= load_data;
         // Latch the nibble as the slot opens so it is settled before the
         // enable goes low and stays put for the whole slot.
         if (slot_end) nib <= display_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
         msd        <= msd_nxt;
`endif
      end
   end

   assign digit_number = {28'b0, nib};

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int BG    = 2;
   localparam int SLOT  = BG + RD;
   localparam int FRAME = ND * SLOT;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_ready;
   logic          hold;
   logic [31:0]   digit_number;
   logic [ND-1:0] digit_en_n;
   logic [2:0]    digit_idx;
   logic          frame_done;

   seg_scan_driver #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(RD),
      .BLANK_GAP  (BG)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .hold        (hold),
      .digit_number(digit_number),
      .digit_en_n  (digit_en_n),
      .digit_idx   (digit_idx),
      .frame_done  (frame_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model state
   int          n_checks = 0;
   int          n_errors = 0;
   int          pos      = 0;      // cycle position inside the frame
   logic [31:0] m_disp   = '0;
   logic [31:0] m_pend   = '0;
   bit          m_pfull  = 1'b0;
   bit          acc_flag = 1'b0;
   int          acc_pos  = -1;
   int          fd_seen  = 0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   int          m_msd    = 0;

   function automatic int msd_of(input logic [31:0] w);
      int m;
      m = 0;
      for (int k = 0; k < ND; k++) if (((w >> (4*k)) & 32'hF) != 0) m = k;
      return m;
   endfunction
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h pos=%0d t=%0t", tag, got, exp, pos, $time);
      end
   endtask

   // Expected outputs derived from the cycle position in the frame.
   task automatic check_all();
      int         slot;
      int         off;
      logic [3:0] exp_en;
      bit         shown;
      slot   = pos / SLOT;
      off    = pos % SLOT;
      exp_en = 4'hF;
      if (off >= BG) begin
         shown = 1'b1;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
         if (slot > m_msd) shown = 1'b0;
`endif
         if (shown) exp_en[slot] = 1'b0;
      end
      check("digit_en_n",   {28'b0, digit_en_n}, {28'b0, exp_en});
      check("digit_idx",    {29'b0, digit_idx},  32'(slot));
      check("frame_done",   {31'b0, frame_done}, {31'b0, (pos == FRAME - 1)});
      check("digit_number", digit_number,        (m_disp >> (4*slot)) & 32'hF);
      check("load_ready",   {31'b0, load_ready}, {31'b0, !m_pfull});
   endtask

   // driver: advance one clock, update the model, check every output
   task automatic tick();
      bit          acc;
      bit          promo;
      logic [31:0] d;
      acc   = (reset_n === 1'b1) && (load_valid === 1'b1) && !m_pfull;
      promo = (reset_n === 1'b1) && (pos == FRAME - 1) && m_pfull && (hold === 1'b0);
      d     = load_data;
      @(posedge clk);
      #1;
      acc_flag = 1'b0;
      if (reset_n !== 1'b1) begin
         pos     = 0;
         m_disp  = '0;
         m_pfull = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
         m_msd   = 0;
`endif
      end else begin
         if (promo) begin
            m_disp  = m_pend;
            m_pfull = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            m_msd   = msd_of(m_disp);
`endif
         end
         if (acc) begin
            m_pend   = d;
            m_pfull  = 1'b1;
            acc_flag = 1'b1;
            acc_pos  = pos;
         end
         pos = (pos + 1) % FRAME;
      end
      if (frame_done === 1'b1) fd_seen++;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pos(input int k);
      int n;
      n = 0;
      while (pos != k && n < 2 * FRAME) begin
         tick();
         n++;
      end
      check("wait_pos", 32'(pos), 32'(k));
   endtask

   // Hold load_valid until the word transfers (bounded).
   task automatic load_word(input logic [31:0] w);
      int n;
      load_valid = 1'b1;
      load_data  = w;
      n = 0;
      acc_flag = 1'b0;
      while (!acc_flag && n < 8 * FRAME) begin
         tick();
         n++;
      end
      check("load_accept", {31'b0, acc_flag}, 32'd1);
      load_valid = 1'b0;
   endtask

   initial begin
      int fd_start;
      reset_n    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      hold       = 1'b0;
      run(3);
      reset_n = 1'b1;

      // reset state
      check("rst_ready", {31'b0, load_ready}, 32'd1);
      check("rst_en",    {28'b0, digit_en_n}, 32'hF);
      check("rst_num",   digit_number,        32'h0);

      // idle scanning: two frames, two frame_done pulses
      fd_start = fd_seen;
      run(2 * FRAME);
      check("fd_count", 32'(fd_seen - fd_start), 32'd2);

      // load mid-frame; shown from next frame only
      wait_pos(8);
      load_word(32'h0000ABCD);
      check("ready_drop", {31'b0, load_ready}, 32'd0);
      wait_pos(20);
      check("old_word_slot3", digit_number, 32'h0);
      wait_pos(0);
      check("ready_back", {31'b0, load_ready}, 32'd1);
      wait_pos(2);
      check("abcd_slot0", digit_number, 32'hD);
      wait_pos(8);
      check("abcd_slot1", digit_number, 32'hC);
      wait_pos(14);
      check("abcd_slot2", digit_number, 32'hB);
      wait_pos(20);
      check("abcd_slot3", digit_number, 32'hA);

      // second load while pending full waits for the boundary
      wait_pos(5);
      load_word(32'h00005678);
      load_word(32'h00001234);
      check("accept_pos", 32'(acc_pos), 32'd0);

      // hold keeps 0x5678 up for three frames
      hold = 1'b1;
      run(3 * FRAME);
      wait_pos(2);
      check("hold_slot0", digit_number, 32'h8);
      check("hold_ready", {31'b0, load_ready}, 32'd0);
      wait_pos(10);
      hold = 1'b0;
      wait_pos(2);
      check("unhold_slot0", digit_number, 32'h4);
      wait_pos(20);
      check("unhold_slot3", digit_number, 32'h1);

      // reset during digit 2 DRIVE discards pending and display
      wait_pos(3);
      load_word(32'h00009999);
      wait_pos(15);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midrst_en",    {28'b0, digit_en_n}, 32'hF);
      check("midrst_idx",   {29'b0, digit_idx},  32'd0);
      check("midrst_ready", {31'b0, load_ready}, 32'd1);
      run(2 * FRAME);
      wait_pos(2);
      check("midrst_disp", digit_number, 32'h0);

      // leading-zero word
      load_word(32'h00000050);
      wait_pos(0);
      wait_pos(8);
      check("lz_slot1_num", digit_number, 32'h5);
      wait_pos(14);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      check("lz_slot2_en", {28'b0, digit_en_n}, 32'hF);
`else
      check("lz_slot2_en", {28'b0, digit_en_n}, 32'hB);
`endif
      load_word(32'h00000000);
      run(2 * FRAME);
      wait_pos(8);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      check("zero_slot1_en", {28'b0, digit_en_n}, 32'hF);
`else
      check("zero_slot1_en", {28'b0, digit_en_n}, 32'hD);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
